// File: rtl/demuxer16_if.sv
// rtl/demuxer16_if.sv - serial-in / parallel-out handshake bundle for demuxer16
interface demuxer16_if #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) ();
  logic             in;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [N_OUT-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             parity_err;

  // slave: the demultiplexer; master: producer plus consumer environment
  modport slave (
    input  in, in_valid, q_ready,
    output in_ready, sel, q, q_valid, parity_err
  );

  modport master (
    output in, in_valid, q_ready,
    input  in_ready, sel, q, q_valid, parity_err
  );
endinterface

// File: rtl/demuxer16.sv
// rtl/demuxer16.sv - serial-to-parallel demux, LSB first; DEMUX16_PARITY_EN adds a trailing even-parity bit
module demuxer16 #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  demuxer16_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_OUT - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_OUT-1:0] q_q, q_d;
  logic             in_ready;
  logic             q_valid;
  logic             accept;
  logic             consume;
  logic             last_bit;

  assign accept   = bus.in_valid && in_ready;
  assign consume  = q_valid && bus.q_ready;
  assign last_bit = (sel_q == SEL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (accept && last_bit) begin
`ifdef DEMUX16_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_HOLD;
`endif
        end
      end
      ST_PAR: begin
        if (accept) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (consume) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    q_valid  = 1'b0;
    case (state_q)
      ST_FILL: in_ready = 1'b1;
      ST_PAR:  in_ready = 1'b1;
      ST_HOLD: q_valid  = 1'b1;
      default: begin
        in_ready = 1'b0;
        q_valid  = 1'b0;
      end
    endcase
  end

  // sel wraps naturally because N_OUT == 2**SEL_W
  always_comb begin
    q_d   = q_q;
    sel_d = sel_q;
    if (state_q == ST_FILL && accept) begin
      q_d[sel_q] = bus.in;
      sel_d      = sel_q + SEL_W'(1);
    end
    if (consume) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      sel_q <= '0;
    end else begin
      q_q   <= q_d;
      sel_q <= sel_d;
    end
  end

`ifdef DEMUX16_PARITY_EN
  logic perr_q, perr_d;

  // even parity over the held data word plus the trailing parity bit
  always_comb begin
    perr_d = perr_q;
    if (state_q == ST_PAR && accept) begin
      perr_d = (^q_q) ^ bus.in;
    end
    if (consume) begin
      perr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.in_ready = in_ready;
  assign bus.q_valid  = q_valid;
  assign bus.sel      = sel_q;
  assign bus.q        = q_q;

endmodule
